disk_uc_fifo: RTL and testbench
===============================

DISK_UC_FIFO -- requirements
Module: disk_uc_fifo

Interface
REQ-001 SHALL have parameter uDEV, default 0, device slot 0..7; register base UBASE = 8*uDEV.
REQ-002 SHALL have parameter DEFAULT_ADDR, default 0, 13-bit reset value of io_addr_base.
REQ-003 SHALL have parameter DEFAULT_INT_VEC, default 0, 9-bit reset value of int_vec.
REQ-004 SHALL have parameter DEFAULT_INT_PRI, default 0, 2-bit reset value of int_priority.
REQ-005 SHALL have parameter DRIVES, default 8, drive count 1..8.
REQ-006 SHALL have parameter FIFO_AW, default 8, log2 of each FIFO's depth in 16-bit words.
REQ-007 SHALL have ports: qclk in 1, the single clock; init in 1, reset, synchronous and active-high.
REQ-008 SHALL have uC bus ports: uADDR in 16; uDATA_in in 16; uDATA_out out 16; uDATA_oe out 1; uWRITE in 1; uSTB in 1, access strobe; uWAIT out 1; uINTERRUPT out 8.
REQ-009 SHALL have config ports: io_addr_base out 13; int_vec out 9; int_priority out 2; mode out 2; loaded out DRIVES; write_protect out DRIVES.
REQ-010 SHALL have Q-side ports: cmd in 3; drive_select in 3; lba in 32; interrupt in 1, one-cycle pulse; fifo_clear in 1.
REQ-011 SHALL have Q-side FIFO ports: rd_data out 16; rd_pop in 1; rd_empty out 1; wr_data in 16; wr_push in 1; wr_full out 1.

Function
REQ-012 SHALL decode offsets from UBASE: 0 CMD (R), 1 DA_LOW (R), 2 DA_HI (R), 3 FIFO (R/W), 4 ADDR (W), 5 INT (W), 6 STAT (W), 7 FCNT (R).
REQ-013 An access SHALL complete on a qclk edge where uSTB=1 and uWAIT=0; the uC holds uSTB, uADDR, uWRITE and uDATA_in stable until then.
REQ-014 Read data SHALL be combinational: CMD={9'b0,drive_select,1'b0,cmd}; DA_LOW=lba[15:0]; DA_HI=lba[31:16]; FIFO=write-FIFO head word; FCNT={wr_count[7:0],rd_count[7:0]}, counts saturating at 255.
REQ-015 uDATA_oe SHALL be 1 only when uSTB=1, uWRITE=0 and uADDR is one of UBASE+0,1,2,3,7; uDATA_out SHALL be 0 otherwise.
REQ-016 Writes: ADDR sets io_addr_base=uDATA_in[12:0]; INT sets {mode,int_priority,int_vec}={uDATA_in[15:14],uDATA_in[10:0]}; STAT sets write_protect=uDATA_in[8+DRIVES-1:8], loaded=uDATA_in[DRIVES-1:0].
REQ-017 Read FIFO (uC->Q): FIFO write pushes uDATA_in; rd_pop removes head; rd_data is head word, valid while rd_empty=0; rd_pop on empty SHALL be ignored.
REQ-018 Write FIFO (Q->uC): wr_push stores wr_data; completed FIFO read pops head; wr_push while wr_full=1 SHALL be ignored and leave contents unchanged.
REQ-019 Each FIFO SHALL hold exactly 2**FIFO_AW words; pointers wrap modulo depth; occupancy counters are FIFO_AW+1 bits.
REQ-020 Simultaneous push and pop on one FIFO SHALL both take effect, count unchanged; on empty FIFO SHALL act as push only.
REQ-021 uWAIT SHALL be 1 when uSTB=1 addresses FIFO and (write with read FIFO full, or read with write FIFO empty), or when init=1; else 0.
REQ-022 fifo_clear SHALL empty both FIFOs next cycle, taking priority over same-cycle push/pop.
REQ-023 uINTERRUPT[uDEV] SHALL set cycle after interrupt=1, clear cycle after a completed CMD read; set wins when simultaneous; other bits SHALL be constant 0.
REQ-024 Config/status outputs SHALL change only on completed writes or reset.

Reset
REQ-025 With init=1 at a qclk edge: io_addr_base=DEFAULT_ADDR, int_vec=DEFAULT_INT_VEC, int_priority=DEFAULT_INT_PRI, mode=0, loaded=0, write_protect=0, uINTERRUPT=0, both FIFOs empty (rd_empty=1, wr_full=0).
REQ-026 init asserted mid-access SHALL abort it; no register or FIFO change from that access.

Verification
REQ-027 Write INT 16'hC0A5 at uDEV=1 (addr 13) -> mode=3, int_priority=0, int_vec=9'h0A5.
REQ-028 Push 256 words via FIFO writes (FIFO_AW=8) -> rd_empty=0, 257th write stalls with uWAIT=1 until one rd_pop, then completes.
REQ-029 FIFO read with write FIFO empty -> uWAIT=1; wr_push 16'h1234 -> read completes next edge returning 16'h1234.
REQ-030 interrupt pulse coinciding with CMD read -> uINTERRUPT[uDEV] remains 1; next CMD read -> 0.
REQ-031 Fill both FIFOs with 10 words, assert fifo_clear with simultaneous wr_push -> both empty, FCNT=0.
REQ-032 Assert init after loading config -> all outputs return to REQ-025 values next edge.

Source files
------------

// File: rtl/disk_uc_fifo_if.sv
// Microcontroller-side bus of the disk controller: address, data, strobe/wait
// handshake and per-device interrupt lines.
interface disk_uc_fifo_if;
    logic [15:0] uADDR;
    logic [15:0] uDATA_in;
    logic [15:0] uDATA_out;
    logic        uDATA_oe;
    logic        uWRITE;
    logic        uSTB;
    logic        uWAIT;
    logic [7:0]  uINTERRUPT;

    modport master (
        output uADDR, uDATA_in, uWRITE, uSTB,
        input  uDATA_out, uDATA_oe, uWAIT, uINTERRUPT
    );

    modport slave (
        input  uADDR, uDATA_in, uWRITE, uSTB,
        output uDATA_out, uDATA_oe, uWAIT, uINTERRUPT
    );
endinterface

// File: rtl/disk_uc_fifo.sv
// Disk controller register window for a microcontroller: 8-word register block
// at 8*uDEV, configuration registers, and a pair of word FIFOs to/from the Q side.
module disk_uc_fifo #(
    parameter int             uDEV            = 0,
    parameter logic [12:0]    DEFAULT_ADDR    = 13'd0,
    parameter logic [8:0]     DEFAULT_INT_VEC = 9'd0,
    parameter logic [1:0]     DEFAULT_INT_PRI = 2'd0,
    parameter int             DRIVES          = 8,
    parameter int             FIFO_AW         = 8
) (
    input  logic                qclk,
    input  logic                init,
    disk_uc_fifo_if.slave       bus,
    output logic [12:0]         io_addr_base,
    output logic [8:0]          int_vec,
    output logic [1:0]          int_priority,
    output logic [1:0]          mode,
    output logic [DRIVES-1:0]   loaded,
    output logic [DRIVES-1:0]   write_protect,
    input  logic [2:0]          cmd,
    input  logic [2:0]          drive_select,
    input  logic [31:0]         lba,
    input  logic                interrupt,
    input  logic                fifo_clear,
    output logic [15:0]         rd_data,
    input  logic                rd_pop,
    output logic                rd_empty,
    input  logic [15:0]         wr_data,
    input  logic                wr_push,
    output logic                wr_full
);
    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0]     UBASE    = 16'(8 * uDEV);
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    function automatic logic [7:0] sat8(input logic [FIFO_AW:0] c);
        logic [31:0] cz;
        cz = 32'(c);
        return (cz > 32'd255) ? 8'hFF : cz[7:0];
    endfunction

    // Read FIFO carries uC -> Q words, write FIFO carries Q -> uC words
    logic [15:0]        rf_mem [DEPTH];
    logic [FIFO_AW-1:0] rf_wp_q, rf_rp_q;
    logic [FIFO_AW:0]   rf_cnt_q;
    logic [15:0]        wf_mem [DEPTH];
    logic [FIFO_AW-1:0] wf_wp_q, wf_rp_q;
    logic [FIFO_AW:0]   wf_cnt_q;

    logic [12:0]        addr_q;
    logic [8:0]         vec_q;
    logic [1:0]         pri_q;
    logic [1:0]         mode_q;
    logic [DRIVES-1:0]  loaded_q;
    logic [DRIVES-1:0]  wp_q;
    logic               int_q;

    logic               in_blk_s, wait_s, acc_s, wr_acc_s, rd_acc_s;
    logic [2:0]         off_s;
    logic               rf_full_s, rf_empty_s, wf_full_s, wf_empty_s;
    logic               rf_push_s, rf_pop_s, wf_push_s, wf_pop_s;
    logic [15:0]        rdat_s;
    logic               oe_s;

    assign in_blk_s   = bus.uSTB && (bus.uADDR[15:3] == UBASE[15:3]);
    assign off_s      = bus.uADDR[2:0];
    assign rf_full_s  = (rf_cnt_q == FULL_CNT);
    assign rf_empty_s = (rf_cnt_q == '0);
    assign wf_full_s  = (wf_cnt_q == FULL_CNT);
    assign wf_empty_s = (wf_cnt_q == '0);

    // A FIFO access stalls until its FIFO can accept/supply a word; init aborts
    assign wait_s   = init || (in_blk_s && (off_s == 3'd3) &&
                      (bus.uWRITE ? rf_full_s : wf_empty_s));
    assign acc_s    = in_blk_s && !wait_s;
    assign wr_acc_s = acc_s && bus.uWRITE;
    assign rd_acc_s = acc_s && !bus.uWRITE;

    assign rf_push_s = wr_acc_s && (off_s == 3'd3);
    assign rf_pop_s  = rd_pop && !rf_empty_s;
    assign wf_push_s = wr_push && !wf_full_s;
    assign wf_pop_s  = rd_acc_s && (off_s == 3'd3);

    // Combinational read-data mux for the register window
    always_comb begin
        rdat_s = 16'd0;
        oe_s   = 1'b0;
        if (in_blk_s && !bus.uWRITE) begin
            case (off_s)
                3'd0: begin rdat_s = {9'd0, drive_select, 1'b0, cmd}; oe_s = 1'b1; end
                3'd1: begin rdat_s = lba[15:0];                        oe_s = 1'b1; end
                3'd2: begin rdat_s = lba[31:16];                       oe_s = 1'b1; end
                3'd3: begin rdat_s = wf_mem[wf_rp_q];                  oe_s = 1'b1; end
                3'd7: begin rdat_s = {sat8(wf_cnt_q), sat8(rf_cnt_q)}; oe_s = 1'b1; end
                default: begin rdat_s = 16'd0; oe_s = 1'b0; end
            endcase
        end else begin
            rdat_s = 16'd0;
            oe_s   = 1'b0;
        end
    end

    // FIFO storage arrays are not reset; occupancy counters define validity
    always_ff @(posedge qclk) begin
        if (rf_push_s && !fifo_clear) begin
            rf_mem[rf_wp_q] <= bus.uDATA_in;
        end
        if (wf_push_s && !fifo_clear && !init) begin
            wf_mem[wf_wp_q] <= wr_data;
        end
    end

    // FIFO pointers and counters; clear overrides any same-cycle push/pop
    always_ff @(posedge qclk) begin
        if (init || fifo_clear) begin
            rf_wp_q  <= '0;
            rf_rp_q  <= '0;
            rf_cnt_q <= '0;
            wf_wp_q  <= '0;
            wf_rp_q  <= '0;
            wf_cnt_q <= '0;
        end else begin
            if (rf_push_s) rf_wp_q <= rf_wp_q + 1'b1;
            if (rf_pop_s)  rf_rp_q <= rf_rp_q + 1'b1;
            case ({rf_push_s, rf_pop_s})
                2'b10:   rf_cnt_q <= rf_cnt_q + 1'b1;
                2'b01:   rf_cnt_q <= rf_cnt_q - 1'b1;
                default: rf_cnt_q <= rf_cnt_q;
            endcase
            if (wf_push_s) wf_wp_q <= wf_wp_q + 1'b1;
            if (wf_pop_s)  wf_rp_q <= wf_rp_q + 1'b1;
            case ({wf_push_s, wf_pop_s})
                2'b10:   wf_cnt_q <= wf_cnt_q + 1'b1;
                2'b01:   wf_cnt_q <= wf_cnt_q - 1'b1;
                default: wf_cnt_q <= wf_cnt_q;
            endcase
        end
    end

    // Configuration registers and the interrupt latch
    always_ff @(posedge qclk) begin
        if (init) begin
            addr_q   <= DEFAULT_ADDR;
            vec_q    <= DEFAULT_INT_VEC;
            pri_q    <= DEFAULT_INT_PRI;
            mode_q   <= 2'd0;
            loaded_q <= '0;
            wp_q     <= '0;
            int_q    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                case (off_s)
                    3'd4: addr_q <= bus.uDATA_in[12:0];
                    3'd5: begin
                        mode_q <= bus.uDATA_in[15:14];
                        pri_q  <= bus.uDATA_in[10:9];
                        vec_q  <= bus.uDATA_in[8:0];
                    end
                    3'd6: begin
                        wp_q     <= bus.uDATA_in[8+DRIVES-1:8];
                        loaded_q <= bus.uDATA_in[DRIVES-1:0];
                    end
                    default: addr_q <= addr_q;
                endcase
            end
            if (interrupt) begin
                int_q <= 1'b1;
            end else if (rd_acc_s && (off_s == 3'd0)) begin
                int_q <= 1'b0;
            end
        end
    end

    assign bus.uDATA_out  = rdat_s;
    assign bus.uDATA_oe   = oe_s;
    assign bus.uWAIT      = wait_s;
    assign bus.uINTERRUPT = int_q ? (8'd1 << uDEV) : 8'd0;

    assign io_addr_base  = addr_q;
    assign int_vec       = vec_q;
    assign int_priority  = pri_q;
    assign mode          = mode_q;
    assign loaded        = loaded_q;
    assign write_protect = wp_q;
    assign rd_data       = rf_mem[rf_rp_q];
    assign rd_empty      = rf_empty_s;
    assign wr_full       = wf_full_s;
endmodule

// File: tb/tb_disk_uc_fifo.sv
// Scoreboard bench for disk_uc_fifo at uDEV=1: register access, both FIFOs, interrupt, clear and init.
module tb_disk_uc_fifo;
    localparam logic [12:0] D_ADDR = 13'h0ABC;
    localparam logic [8:0]  D_VEC  = 9'h155;
    localparam logic [1:0]  D_PRI  = 2'd2;
    localparam logic [15:0] A_CMD = 16'd8, A_DALO = 16'd9, A_DAHI = 16'd10, A_FIFO = 16'd11;
    localparam logic [15:0] A_ADDR = 16'd12, A_INT = 16'd13, A_STAT = 16'd14, A_FCNT = 16'd15;

    logic qclk = 1'b0;
    logic init = 1'b1;
    logic [12:0] io_addr_base;
    logic [8:0]  int_vec;
    logic [1:0]  int_priority, mode;
    logic [7:0]  loaded, write_protect;
    logic [2:0]  cmd = 3'd0, drive_select = 3'd0;
    logic [31:0] lba = 32'd0;
    logic        interrupt = 1'b0, fifo_clear = 1'b0, rd_pop = 1'b0, wr_push = 1'b0;
    logic [15:0] rd_data, wr_data = 16'd0;
    logic        rd_empty, wr_full;

    disk_uc_fifo_if bus();

    disk_uc_fifo #(.uDEV(1), .DEFAULT_ADDR(D_ADDR), .DEFAULT_INT_VEC(D_VEC),
                   .DEFAULT_INT_PRI(D_PRI), .DRIVES(8), .FIFO_AW(8)) dut (
        .qclk(qclk), .init(init), .bus(bus),
        .io_addr_base(io_addr_base), .int_vec(int_vec), .int_priority(int_priority),
        .mode(mode), .loaded(loaded), .write_protect(write_protect),
        .cmd(cmd), .drive_select(drive_select), .lba(lba), .interrupt(interrupt),
        .fifo_clear(fifo_clear), .rd_data(rd_data), .rd_pop(rd_pop), .rd_empty(rd_empty),
        .wr_data(wr_data), .wr_push(wr_push), .wr_full(wr_full)
    );

    always #5 qclk = ~qclk;

    typedef struct packed { logic [15:0] d; logic oe; } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read that completes on the coming edge is scored here
    always @(negedge qclk) begin
        if (bus.uSTB && !bus.uWAIT && !bus.uWRITE) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: addr %h data %h", bus.uADDR, bus.uDATA_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("read_data", {16'd0, bus.uDATA_out}, {16'd0, e.d});
                chk("read_oe", {31'd0, bus.uDATA_oe}, {31'd0, e.oe});
            end
        end
    end

    task automatic tick();
        @(posedge qclk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge qclk);
            if (!bus.uWAIT) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: uWAIT stuck at 1 required 0", name);
        end
        tick();
        bus.uSTB = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        tick();
        bus.uADDR = a; bus.uDATA_in = d; bus.uWRITE = 1'b1; bus.uSTB = 1'b1;
        wait_done("write");
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] d, input logic oe);
        exp_q.push_back('{d: d, oe: oe});
        tick();
        bus.uADDR = a; bus.uWRITE = 1'b0; bus.uSTB = 1'b1;
        wait_done("read");
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, "_addr"}, {19'd0, io_addr_base}, {19'd0, D_ADDR});
        chk({tag, "_vec"}, {23'd0, int_vec}, {23'd0, D_VEC});
        chk({tag, "_pri"}, {30'd0, int_priority}, {30'd0, D_PRI});
        chk({tag, "_mode"}, {30'd0, mode}, 32'd0);
        chk({tag, "_loaded"}, {24'd0, loaded}, 32'd0);
        chk({tag, "_wp"}, {24'd0, write_protect}, 32'd0);
        chk({tag, "_uint"}, {24'd0, bus.uINTERRUPT}, 32'd0);
        chk({tag, "_rd_empty"}, {31'd0, rd_empty}, 32'd1);
        chk({tag, "_wr_full"}, {31'd0, wr_full}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.uADDR = 16'd0; bus.uDATA_in = 16'd0; bus.uWRITE = 1'b0; bus.uSTB = 1'b0;
        repeat (3) tick();
        @(negedge qclk);
        chk_defaults("reset");
        chk("reset_uwait", {31'd0, bus.uWAIT}, 32'd1);
        tick();
        init = 1'b0;

        // Config writes
        bus_write(A_INT, 16'hC0A5);
        @(negedge qclk);
        chk("int_mode", {30'd0, mode}, 32'd3);
        chk("int_pri", {30'd0, int_priority}, 32'd0);
        chk("int_vec", {23'd0, int_vec}, 32'h0A5);
        bus_write(A_ADDR, 16'hFFFF);
        bus_write(A_STAT, 16'hA55A);
        @(negedge qclk);
        chk("addr_base", {19'd0, io_addr_base}, 32'h1FFF);
        chk("stat_wp", {24'd0, write_protect}, 32'hA5);
        chk("stat_loaded", {24'd0, loaded}, 32'h5A);

        // Status reads and non-readable addresses
        cmd = 3'd5; drive_select = 3'd6; lba = 32'hDEADBEEF;
        bus_read(A_CMD, 16'h0065, 1'b1);
        bus_read(A_DALO, 16'hBEEF, 1'b1);
        bus_read(A_DAHI, 16'hDEAD, 1'b1);
        bus_read(A_ADDR, 16'h0000, 1'b0);
        bus_read(16'd0, 16'h0000, 1'b0);
        bus_read(A_FCNT, 16'h0000, 1'b1);

        // Interrupt set / clear by CMD read / set wins
        tick(); interrupt = 1'b1;
        tick(); interrupt = 1'b0;
        @(negedge qclk);
        chk("int_set", {24'd0, bus.uINTERRUPT}, 32'h02);
        bus_read(A_CMD, 16'h0065, 1'b1);
        @(negedge qclk);
        chk("int_clr", {24'd0, bus.uINTERRUPT}, 32'h00);
        exp_q.push_back('{d: 16'h0065, oe: 1'b1});
        tick(); interrupt = 1'b1; bus.uADDR = A_CMD; bus.uWRITE = 1'b0; bus.uSTB = 1'b1;
        tick(); interrupt = 1'b0; bus.uSTB = 1'b0;
        @(negedge qclk);
        chk("int_set_wins", {24'd0, bus.uINTERRUPT}, 32'h02);
        bus_read(A_CMD, 16'h0065, 1'b1);
        @(negedge qclk);
        chk("int_clr2", {24'd0, bus.uINTERRUPT}, 32'h00);

        // FIFO read stalls on empty write FIFO, then returns the pushed word
        exp_q.push_back('{d: 16'h1234, oe: 1'b1});
        tick(); bus.uADDR = A_FIFO; bus.uWRITE = 1'b0; bus.uSTB = 1'b1;
        repeat (2) tick();
        wr_push = 1'b1; wr_data = 16'h1234;
        @(negedge qclk);
        chk("fifo_rd_wait", {31'd0, bus.uWAIT}, 32'd1);
        tick(); wr_push = 1'b0;
        tick(); bus.uSTB = 1'b0;

        // Fill the read FIFO, then the 257th write stalls until one rd_pop
        for (int i = 0; i < 256; i++) bus_write(A_FIFO, 16'(16'h0300 + i));
        @(negedge qclk);
        chk("rf_not_empty", {31'd0, rd_empty}, 32'd0);
        chk("rf_head0", {16'd0, rd_data}, 32'h0300);
        tick(); bus.uADDR = A_FIFO; bus.uDATA_in = 16'hEEEE; bus.uWRITE = 1'b1; bus.uSTB = 1'b1;
        repeat (2) tick();
        @(negedge qclk);
        chk("rf_full_wait", {31'd0, bus.uWAIT}, 32'd1);
        tick(); rd_pop = 1'b1;
        tick(); rd_pop = 1'b0;
        @(negedge qclk);
        chk("rf_wait_released", {31'd0, bus.uWAIT}, 32'd0);
        chk("rf_head1", {16'd0, rd_data}, 32'h0301);
        tick(); bus.uSTB = 1'b0;
        bus_read(A_FCNT, 16'h00FF, 1'b1);

        // Ten words each way, then clear with a simultaneous push
        tick(); fifo_clear = 1'b1;
        tick(); fifo_clear = 1'b0;
        for (int i = 0; i < 10; i++) bus_write(A_FIFO, 16'(16'hA000 + i));
        for (int i = 0; i < 10; i++) begin
            tick(); wr_push = 1'b1; wr_data = 16'(16'hB000 + i);
        end
        tick(); wr_push = 1'b0;
        bus_read(A_FCNT, 16'h0A0A, 1'b1);
        @(negedge qclk);
        chk("rf_head_a0", {16'd0, rd_data}, 32'hA000);
        bus_read(A_FIFO, 16'hB000, 1'b1);
        bus_read(A_FIFO, 16'hB001, 1'b1);
        bus_read(A_FCNT, 16'h080A, 1'b1);
        tick(); fifo_clear = 1'b1; wr_push = 1'b1; wr_data = 16'h7777;
        tick(); fifo_clear = 1'b0; wr_push = 1'b0;
        @(negedge qclk);
        chk("clr_rd_empty", {31'd0, rd_empty}, 32'd1);
        chk("clr_wr_full", {31'd0, wr_full}, 32'd0);
        bus_read(A_FCNT, 16'h0000, 1'b1);

        // Overfill the write FIFO; the extra push must not disturb the head
        for (int i = 0; i < 257; i++) begin
            tick(); wr_push = 1'b1; wr_data = 16'(16'h5000 + i);
        end
        tick(); wr_push = 1'b0;
        @(negedge qclk);
        chk("wf_full", {31'd0, wr_full}, 32'd1);
        bus_read(A_FIFO, 16'h5000, 1'b1);
        bus_read(A_FIFO, 16'h5001, 1'b1);
        bus_read(A_FCNT, 16'hFE00, 1'b1);

        // init during a pending register write restores defaults and aborts it
        tick(); interrupt = 1'b1;
        tick(); interrupt = 1'b0;
        tick(); init = 1'b1;
        bus.uADDR = A_ADDR; bus.uDATA_in = 16'h0123; bus.uWRITE = 1'b1; bus.uSTB = 1'b1;
        @(negedge qclk);
        chk("init_uwait", {31'd0, bus.uWAIT}, 32'd1);
        tick();
        @(negedge qclk);
        chk_defaults("init");
        tick(); bus.uSTB = 1'b0;
        tick(); init = 1'b0;
        @(negedge qclk);
        chk("abort_addr", {19'd0, io_addr_base}, {19'd0, D_ADDR});
        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
